// File: rtl/msg_scroller_pkg.sv
// msg_pkg: shared definitions for the message scroller.
//   msg_state_e   - sequencer states
//   ROWS          - LED matrix rows (height of one column pattern)
//   CODE_BLANK    - character code that bypasses gen_char and scrolls one blank column
//   CHAR_MAX_COL  - last column index a character may use when gen_finish never arrives
package msg_pkg;

    localparam int         ROWS         = 7;
    localparam logic [3:0] CODE_BLANK   = 4'hF;
    localparam logic [3:0] CHAR_MAX_COL = 4'd15;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FETCH,
        SHIFT,
        WAIT,
        FLUSH,
        DONE
    } msg_state_e;

endpackage

// File: rtl/msg_scroller_matrix_scan.sv
// matrix_scan: column-scan driver for the LED matrix.
//   clk, reset  - rising-edge clock, synchronous active-high reset
//   window      - COLS columns of ROWS bits; column k at [k*ROWS +: ROWS]
//   col_sel     - one-hot active-high column enable, rotates left every SCAN_DIV cycles
//   row_data    - registered pattern of the column selected in the previous cycle
module matrix_scan
    import msg_pkg::*;
#(
    parameter int COLS     = 5,
    parameter int SCAN_DIV = 50_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [COLS*ROWS-1:0] window,
    output logic [COLS-1:0]      col_sel,
    output logic [ROWS-1:0]      row_data
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [COLS-1:0]   col_sel_q, col_sel_d;
    logic [ROWS-1:0]   row_data_q, row_data_d;
    logic              scan_tick;

    always_comb begin
        scan_tick  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
        scan_cnt_d = scan_tick ? '0 : scan_cnt_q + SCAN_W'(1);
        col_sel_d  = scan_tick ? {col_sel_q[COLS-2:0], col_sel_q[COLS-1]} : col_sel_q;
        // Uses the window as it is this cycle, so a simultaneous shift shows up one cycle later.
        row_data_d = '0;
        for (int k = 0; k < COLS; k++) begin
            if (col_sel_q[k]) begin
                row_data_d = window[k*ROWS +: ROWS];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt_q <= '0;
            col_sel_q  <= COLS'(1);
            row_data_q <= '0;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            col_sel_q  <= col_sel_d;
            row_data_q <= row_data_d;
        end
    end

    assign col_sel  = col_sel_q;
    assign row_data = row_data_q;

endmodule

// File: rtl/msg_scroller.sv
// msg_scroller: scrolls a message of 4-bit character codes across a 5x7 LED matrix.
//   start       - one-cycle pulse; accepted only in IDLE and not during reset
//   msg_codes   - char i at [4i+3:4i], captured when start is accepted
//   char_code / char_col - registered request to the external gen_char lookup
//   gen_col / gen_finish - gen_char response, sampled one cycle after the request settles
//   col_sel / row_data   - column scan outputs (see matrix_scan)
//   busy        - high from accepted start until done
//   done        - one-cycle pulse at end of message (busy is already low)
// Build option SCROLL_LOOP_EN: when defined the message repeats forever with no
// flush and no done; when undefined one pass is followed by COLS blank columns.
// start has no ready: it is a fire-and-forget pulse that is dropped while busy.
module msg_scroller
    import msg_pkg::*;
#(
    parameter int MSG_LEN    = 8,
    parameter int COLS       = 5,
    parameter int SCROLL_DIV = 25_000_000,
    parameter int SCAN_DIV   = 50_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [4*MSG_LEN-1:0] msg_codes,
    output logic [3:0]           char_code,
    output logic [3:0]           char_col,
    input  logic [ROWS-1:0]      gen_col,
    input  logic                 gen_finish,
    output logic [COLS-1:0]      col_sel,
    output logic [ROWS-1:0]      row_data,
    output logic                 busy,
    output logic                 done
);

    localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int SCR_W = $clog2(SCROLL_DIV);
    localparam int FL_W  = $clog2(COLS + 1);
    localparam int WIN_W = COLS * ROWS;

    msg_state_e           state_q, state_d;
    logic [4*MSG_LEN-1:0] msg_q, msg_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [3:0]           col_q, col_d;
    logic [3:0]           char_code_q, char_code_d;
    logic [3:0]           char_col_q, char_col_d;
    logic [WIN_W-1:0]     window_q, window_d;
    logic [SCR_W-1:0]     scroll_cnt_q, scroll_cnt_d;
    logic [FL_W-1:0]      flush_q, flush_d;

    logic                 scroll_tick;
    logic                 active;
    logic [3:0]           cur_code;
    logic [ROWS-1:0]      new_col;
    logic                 last_col;
    logic                 last_char;

    assign cur_code = msg_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        state_d     = state_q;
        msg_d       = msg_q;
        idx_d       = idx_q;
        col_d       = col_q;
        char_code_d = char_code_q;
        char_col_d  = char_col_q;
        window_d    = window_q;
        flush_d     = flush_q;

        active      = (state_q != IDLE) && (state_q != DONE);
        scroll_tick = (scroll_cnt_q == SCR_W'(SCROLL_DIV - 1));
        // The scroll counter is free-running while busy so step spacing does not
        // depend on how long the fetch pipeline takes.
        scroll_cnt_d = (!active || scroll_tick) ? '0 : scroll_cnt_q + SCR_W'(1);

        new_col   = (char_code_q == CODE_BLANK) ? '0 : gen_col;
        last_col  = (char_code_q == CODE_BLANK) || gen_finish || (col_q == CHAR_MAX_COL);
        last_char = (idx_q == IDX_W'(MSG_LEN - 1));

        case (state_q)
            IDLE: begin
                if (start) begin
                    msg_d   = msg_codes;
                    idx_d   = '0;
                    col_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                char_code_d = cur_code;
                char_col_d  = col_q;
                state_d     = FETCH;
            end
            FETCH: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                window_d = {window_q[WIN_W-ROWS-1:0], new_col};
                state_d  = WAIT;
                if (last_col) begin
                    col_d = '0;
                    if (last_char) begin
                        idx_d = '0;
`ifdef SCROLL_LOOP_EN
                        state_d = WAIT;
`else
                        flush_d = '0;
                        state_d = FLUSH;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    col_d = col_q + 4'd1;
                end
            end
            WAIT: begin
                if (scroll_tick) begin
                    char_code_d = cur_code;
                    char_col_d  = col_q;
                    state_d     = FETCH;
                end
            end
            FLUSH: begin
                if (scroll_tick) begin
                    window_d = {window_q[WIN_W-ROWS-1:0], {ROWS{1'b0}}};
                    if (flush_q == FL_W'(COLS - 1)) begin
                        state_d = DONE;
                    end else begin
                        flush_d = flush_q + FL_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            msg_q        <= '0;
            idx_q        <= '0;
            col_q        <= '0;
            char_code_q  <= '0;
            char_col_q   <= '0;
            window_q     <= '0;
            scroll_cnt_q <= '0;
            flush_q      <= '0;
        end else begin
            state_q      <= state_d;
            msg_q        <= msg_d;
            idx_q        <= idx_d;
            col_q        <= col_d;
            char_code_q  <= char_code_d;
            char_col_q   <= char_col_d;
            window_q     <= window_d;
            scroll_cnt_q <= scroll_cnt_d;
            flush_q      <= flush_d;
        end
    end

    assign char_code = char_code_q;
    assign char_col  = char_col_q;
    assign busy      = active;
    assign done      = (state_q == DONE);

    matrix_scan #(
        .COLS     (COLS),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk      (clk),
        .reset    (reset),
        .window   (window_q),
        .col_sel  (col_sel),
        .row_data (row_data)
    );

endmodule

// File: tb/tb_msg_scroller.sv
// Bench for msg_scroller: random gen_char font, random messages, and a
// schedule-based reference model of the visible window and output pins.
module tb_msg_scroller;

    localparam int MSG_LEN    = 2;
    localparam int COLS       = 5;
    localparam int SCROLL_DIV = 4;
    localparam int SCAN_DIV   = 2;

    // ---------------- clock / reset ----------------
    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic [4*MSG_LEN-1:0] msg_codes = '0;
    logic [3:0]           char_code, char_col;
    logic [6:0]           gen_col;
    logic                 gen_finish;
    logic [COLS-1:0]      col_sel;
    logic [6:0]           row_data;
    logic                 busy, done;

    always #5 clk = ~clk;

    msg_scroller #(
        .MSG_LEN    (MSG_LEN),
        .COLS       (COLS),
        .SCROLL_DIV (SCROLL_DIV),
        .SCAN_DIV   (SCAN_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .msg_codes  (msg_codes),
        .char_code  (char_code),
        .char_col   (char_col),
        .gen_col    (gen_col),
        .gen_finish (gen_finish),
        .col_sel    (col_sel),
        .row_data   (row_data),
        .busy       (busy),
        .done       (done)
    );

    // ---------------- gen_char model ----------------
    logic [6:0] font [16][16];
    logic       no_finish = 1'b0;

    assign gen_col    = font[char_code][char_col];
    assign gen_finish = !no_finish && (char_col == 4'd5);

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // The message becomes a list of columns; each column has a time (edges after
    // the accepted start) at which the request pins change and at which it
    // enters the window. Ticks fall on multiples of SCROLL_DIV; the first
    // column goes straight through the fetch pipeline.
    logic [6:0] exp_q[$];
    int         exp_t_q[$];
    logic [7:0] char_v_q[$];
    int         char_t_q[$];

    logic [6:0] m_win [COLS];
    logic [6:0] m_row = '0;
    logic [3:0] m_code = '0, m_col = '0;
    logic       m_busy = 1'b0, m_done = 1'b0, m_active = 1'b0;
    int         m_t = 0, m_done_t = 0, m_rel = 0;

    function automatic int cur_sel();
        return (m_rel / SCAN_DIV) % COLS;
    endfunction

    task automatic build_sched(input logic [4*MSG_LEN-1:0] codes, input logic nf);
        int k, last;
        logic [3:0] c;
        k = 0;
        for (int i = 0; i < MSG_LEN; i++) begin
            c    = codes[4*i +: 4];
            last = (c == 4'hF) ? 0 : (nf ? 15 : 5);
            for (int j = 0; j <= last; j++) begin
                char_t_q.push_back(k == 0 ? 1 : SCROLL_DIV * k);
                char_v_q.push_back({c, 4'(j)});
                exp_t_q.push_back(k == 0 ? 3 : SCROLL_DIV * k + 2);
                exp_q.push_back(c == 4'hF ? 7'd0 : font[c][j]);
                k++;
            end
        end
        for (int j = 1; j <= COLS; j++) begin
            exp_t_q.push_back(SCROLL_DIV * (k - 1) + SCROLL_DIV * j);
            exp_q.push_back(7'd0);
        end
        m_done_t = SCROLL_DIV * (k - 1) + SCROLL_DIV * COLS;
    endtask

    always @(posedge clk) begin
        m_row = reset ? 7'd0 : m_win[cur_sel()];
        if (reset) begin
            for (int i = 0; i < COLS; i++) m_win[i] = '0;
            m_rel = 0; m_active = 0; m_busy = 0; m_done = 0;
            m_code = '0; m_col = '0;
            exp_q.delete(); exp_t_q.delete(); char_v_q.delete(); char_t_q.delete();
        end else begin
            m_rel++;
            m_done = 0;
            if (m_active) begin
                m_t++;
                if (char_t_q.size() > 0 && char_t_q[0] == m_t) begin
                    {m_code, m_col} = char_v_q.pop_front();
                    void'(char_t_q.pop_front());
                end
                if (exp_t_q.size() > 0 && exp_t_q[0] == m_t) begin
                    for (int i = COLS - 1; i > 0; i--) m_win[i] = m_win[i-1];
                    m_win[0] = exp_q.pop_front();
                    void'(exp_t_q.pop_front());
                end
                if (m_t == m_done_t) begin m_busy = 0; m_done = 1; end
                if (m_t == m_done_t + 1) m_active = 0;
            end else if (start) begin
                build_sched(msg_codes, no_finish);
                m_t = 0; m_active = 1; m_busy = 1;
            end
        end
    end

    always @(negedge clk) begin
        if ($time > 0) begin
            check("col_sel",   32'(col_sel),   32'(1 << cur_sel()));
            check("row_data",  32'(row_data),  32'(m_row));
            check("busy",      32'(busy),      32'(m_busy));
            check("done",      32'(done),      32'(m_done));
            check("char_code", 32'(char_code), 32'(m_code));
            check("char_col",  32'(char_col),  32'(m_col));
        end
    end

    initial begin
        for (int c = 0; c < 16; c++)
            for (int j = 0; j < 16; j++) font[c][j] = 7'($urandom_range(1, 127));
        for (int i = 0; i < COLS; i++) m_win[i] = '0;
    end

    // ---------------- driver tasks ----------------
    task automatic run_msg(input logic [4*MSG_LEN-1:0] codes);
        int budget;
        int poke;
        @(negedge clk);
        msg_codes = codes;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        msg_codes = $urandom;           // must have been latched already
        poke = $urandom_range(2, 18);
        repeat (poke) @(negedge clk);
        msg_codes = $urandom;
        start     = 1'b1;               // ignored while busy
        @(negedge clk);
        start     = 1'b0;
        budget = 400;
        while (m_active && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("msg_timeout", 32'(m_active), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [3:0] rand_code();
        return ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
    endfunction

    task automatic mid_reset();
        int budget;
        @(negedge clk);
        msg_codes = {4'h7, 4'h2};
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        budget = 200;
        while (!(exp_t_q.size() > 0 && exp_t_q[0] == m_t + 1 && m_t > 6) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("shift_wait_timeout", 32'd0, 32'd1);
        reset = 1'b1;
        start = 1'b1;                   // start during reset is ignored
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        run_msg({4'hC, 4'hA});          // A then C
        run_msg({4'hA, 4'hF});          // blank then A
        no_finish = 1'b1;
        run_msg({4'hB, 4'h3});          // 16 columns per character
        no_finish = 1'b0;
        run_msg({4'hF, 4'hF});
        for (int r = 0; r < 4; r++) run_msg({rand_code(), rand_code()});
        mid_reset();
        run_msg({4'h1, 4'h9});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
